// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute sequencer that owns PC, IR
// and the shared memory port. Optional single-step mode: SEQ_SINGLE_STEP_EN.
module cpu_sequencer #(
    parameter int          ADDR_W   = 16,
    parameter int          DATA_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] instr,
    input  logic              ctl_reg_write,
    input  logic              ctl_mem_write,
    input  logic              ctl_mem_to_reg,
    input  logic              ctl_mem_addr_sel,
    input  logic              ctl_jump,
    input  logic              ctl_branch,
    input  logic              ctl_halt,
    input  logic              alu_zero,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    output logic              rf_we,
    output logic              rf_wdata_sel,
    output logic [DATA_W-1:0] load_data,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [2:0]        state
`ifdef SEQ_SINGLE_STEP_EN
    ,
    input  logic              step_req
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
`ifdef SEQ_SINGLE_STEP_EN
        ,
        S_PAUSE  = 3'd6
`endif
    } state_t;

    // Where an instruction goes once it is finished.
`ifdef SEQ_SINGLE_STEP_EN
    localparam state_t S_RET  = S_PAUSE;
    localparam state_t S_BOOT = S_PAUSE;
`else
    localparam state_t S_RET  = S_FETCH;
    localparam state_t S_BOOT = S_FETCH;
`endif

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_instr;
    logic [DATA_W-1:0]   r_load_data;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_rf_we;
    logic                r_rf_wdata_sel;
    logic                r_halted;
    logic                r_is_load;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [DATA_W-1:0]   w_instr_nxt;
    logic [DATA_W-1:0]   w_load_data_nxt;
    logic                w_mem_req_nxt;
    logic                w_mem_we_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [DATA_W-1:0]   w_mem_wdata_nxt;
    logic                w_rf_we_nxt;
    logic                w_rf_wdata_sel_nxt;
    logic                w_halted_nxt;
    logic                w_is_load_nxt;
    logic                w_xfer;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_jmp_tgt;
    logic [ADDR_W-1:0]   w_br_tgt;
    logic                w_step;

    assign w_xfer    = r_mem_req & mem_ready;
    assign w_pc_inc  = r_pc + PC_ONE;
    assign w_jmp_tgt = {{(ADDR_W-12){1'b0}}, r_instr[11:0]};
    assign w_br_tgt  = r_pc + {{(ADDR_W-8){r_instr[7]}}, r_instr[7:0]};

`ifdef SEQ_SINGLE_STEP_EN
    assign w_step = step_req;
`else
    assign w_step = 1'b0;
`endif

    // Next-state and next-output decode; registered outputs keep mem/rf glitch-free.
    always_comb begin
        w_state_nxt        = r_state;
        w_pc_nxt           = r_pc;
        w_instr_nxt        = r_instr;
        w_load_data_nxt    = r_load_data;
        w_mem_req_nxt      = 1'b0;
        w_mem_we_nxt       = r_mem_we;
        w_mem_addr_nxt     = r_mem_addr;
        w_mem_wdata_nxt    = r_mem_wdata;
        w_rf_wdata_sel_nxt = r_rf_wdata_sel;
        w_halted_nxt       = r_halted;
        w_is_load_nxt      = r_is_load;

        case (r_state)
            S_FETCH: begin
                if (w_xfer) begin
                    w_instr_nxt = mem_rdata;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (ctl_halt) begin
                    w_state_nxt  = S_HALTED;
                    w_halted_nxt = 1'b1;
                end else if (ctl_jump) begin
                    w_pc_nxt    = w_jmp_tgt;
                    w_state_nxt = S_RET;
                end else if (ctl_branch) begin
                    if (alu_zero) begin
                        w_pc_nxt = w_br_tgt;
                    end
                    w_state_nxt = S_RET;
                end else if (ctl_mem_addr_sel) begin
                    w_mem_addr_nxt  = alu_result;
                    w_mem_wdata_nxt = store_data;
                    w_mem_we_nxt    = ctl_mem_write;
                    w_is_load_nxt   = ctl_mem_to_reg & ~ctl_mem_write;
                    w_state_nxt     = S_MEM;
                end else if (ctl_reg_write) begin
                    w_rf_wdata_sel_nxt = 1'b0;
                    w_state_nxt        = S_WB;
                end else begin
                    w_state_nxt = S_RET;
                end
            end
            S_MEM: begin
                if (w_xfer) begin
                    if (r_is_load) begin
                        w_load_data_nxt    = mem_rdata;
                        w_rf_wdata_sel_nxt = 1'b1;
                        w_state_nxt        = S_WB;
                    end else begin
                        w_state_nxt = S_RET;
                    end
                end
            end
            S_WB: begin
                w_state_nxt = S_RET;
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (w_step) begin
                    w_state_nxt = S_FETCH;
                end
            end
`endif
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase

        // A request is presented on the very first cycle of FETCH/MEM,
        // so zero-wait memory completes a transfer in one cycle.
        if (w_state_nxt == S_FETCH) begin
            w_mem_req_nxt  = 1'b1;
            w_mem_we_nxt   = 1'b0;
            w_mem_addr_nxt = w_pc_nxt;
        end else if (w_state_nxt == S_MEM) begin
            w_mem_req_nxt = 1'b1;
        end

        w_rf_we_nxt = (w_state_nxt == S_WB);
    end

    // State and datapath registers; reset clears every request strobe at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_BOOT;
            r_pc           <= PC_RST;
            r_instr        <= '0;
            r_load_data    <= '0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_rf_we        <= 1'b0;
            r_rf_wdata_sel <= 1'b0;
            r_halted       <= 1'b0;
            r_is_load      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_pc           <= w_pc_nxt;
            r_instr        <= w_instr_nxt;
            r_load_data    <= w_load_data_nxt;
            r_mem_req      <= w_mem_req_nxt;
            r_mem_we       <= w_mem_we_nxt;
            r_mem_addr     <= w_mem_addr_nxt;
            r_mem_wdata    <= w_mem_wdata_nxt;
            r_rf_we        <= w_rf_we_nxt;
            r_rf_wdata_sel <= w_rf_wdata_sel_nxt;
            r_halted       <= w_halted_nxt;
            r_is_load      <= w_is_load_nxt;
        end
    end

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign instr        = r_instr;
    assign rf_we        = r_rf_we;
    assign rf_wdata_sel = r_rf_wdata_sel;
    assign load_data    = r_load_data;
    assign pc           = r_pc;
    assign halted       = r_halted;
    assign state        = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed programs, reactive wait-state memory,
// instruction-level expected-trace model checked every cycle.
`timescale 1ns/1ps
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ready;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] instr;
    logic        ctl_reg_write, ctl_mem_write, ctl_mem_to_reg;
    logic        ctl_mem_addr_sel, ctl_jump, ctl_branch, ctl_halt;
    logic        alu_zero;
    logic [15:0] alu_result, store_data;
    logic        rf_we, rf_wdata_sel, halted;
    logic [15:0] load_data, pc;
    logic [2:0]  state;
    logic        ready_force = 1'b0;

`ifdef SEQ_SINGLE_STEP_EN
    logic        step_req = 1'b1;
    localparam logic [2:0] BOOT_ST = 3'd6;
`else
    localparam logic [2:0] BOOT_ST = 3'd0;
`endif

    cpu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .instr(instr),
        .ctl_reg_write(ctl_reg_write), .ctl_mem_write(ctl_mem_write),
        .ctl_mem_to_reg(ctl_mem_to_reg), .ctl_mem_addr_sel(ctl_mem_addr_sel),
        .ctl_jump(ctl_jump), .ctl_branch(ctl_branch), .ctl_halt(ctl_halt),
        .alu_zero(alu_zero), .alu_result(alu_result), .store_data(store_data),
        .rf_we(rf_we), .rf_wdata_sel(rf_wdata_sel), .load_data(load_data),
        .pc(pc), .halted(halted), .state(state)
`ifdef SEQ_SINGLE_STEP_EN
        , .step_req(step_req)
`endif
    );

    always #5 clk = ~clk;

    // Stub control unit: 1 ADD, 2 LD, 3 ST, 4 JMP, 5 BEQZ, 6 MOV, F HLT.
    always_comb begin
        ctl_reg_write = 1'b0; ctl_mem_write = 1'b0; ctl_mem_to_reg = 1'b0;
        ctl_mem_addr_sel = 1'b0; ctl_jump = 1'b0; ctl_branch = 1'b0;
        ctl_halt = 1'b0;
        case (instr[15:12])
            4'h1, 4'h6: ctl_reg_write = 1'b1;
            4'h2: begin
                ctl_mem_addr_sel = 1'b1; ctl_mem_to_reg = 1'b1;
                ctl_reg_write = 1'b1;
            end
            4'h3: begin ctl_mem_addr_sel = 1'b1; ctl_mem_write = 1'b1; end
            4'h4: ctl_jump = 1'b1;
            4'h5: ctl_branch = 1'b1;
            4'hF: ctl_halt = 1'b1;
            default: ;
        endcase
    end

    // Stub datapath: zero flag from instr[11], address 0x200+imm8.
    always_comb begin
        alu_zero   = instr[11];
        alu_result = 16'h0200 + {8'h00, instr[7:0]};
        store_data = {instr[7:0], ~instr[7:0]};
    end

    logic [15:0] mem [0:65535];
    int          wtab [0:255];
    int          cnt;
    logic [7:0]  acc_idx;

    assign mem_rdata = mem[mem_addr];
    assign mem_ready = ready_force | (mem_req & (cnt >= wtab[acc_idx]));

    // Memory responder: per-access wait count taken from wtab.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 0;
            acc_idx <= 8'd0;
        end else if (mem_req && mem_ready) begin
            cnt <= 0;
            acc_idx <= acc_idx + 8'd1;
        end else if (mem_req) begin
            cnt <= cnt + 1;
        end
    end

    int cyc, rfwe_cnt, rfwe_cyc, req_cyc;

    // Event monitor: cycle index of the first request and of rf_we pulses.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0; rfwe_cnt <= 0; rfwe_cyc <= 0; req_cyc <= 0;
        end else begin
            cyc <= cyc + 1;
            if (rf_we) begin
                rfwe_cnt <= rfwe_cnt + 1;
                rfwe_cyc <= cyc;
            end
            if (mem_req && req_cyc == 0) req_cyc <= cyc;
        end
    end

    typedef struct {
        bit          req;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        bit          rfwe;
        bit          sel;
        logic [15:0] pc;
        bit          hlt;
        bit          ldchk;
        logic [15:0] ld;
    } exp_t;

    exp_t        exp_a [0:511];
    int          exp_n, exp_rd, nacc;
    logic [15:0] mpc;
    int          n_cmp, n_bad;

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic push(input bit rq, input bit we, input logic [15:0] a,
                        input logic [15:0] wd, input bit rw, input bit sl,
                        input bit hl, input bit lc, input logic [15:0] ld);
        exp_a[exp_n] = '{rq, we, a, wd, rw, sl, mpc, hl, lc, ld};
        exp_n++;
    endtask

    // Instruction-level model: emits one expected record per clock cycle.
    task automatic model_run(input int n, input int fw, input int dw);
        logic [15:0] w, a;
        for (int i = 0; i < n; i++) begin
            w = mem[mpc];
            a = 16'h0200 + {8'h00, w[7:0]};
            wtab[nacc] = fw; nacc++;
            for (int k = 0; k <= fw; k++) push(1, 0, mpc, 0, 0, 0, 0, 0, 0);
            mpc = mpc + 16'd1;
            push(0, 0, 0, 0, 0, 0, 0, 0, 0);
            push(0, 0, 0, 0, 0, 0, 0, 0, 0);
            case (w[15:12])
                4'hF: begin
                    for (int k = 0; k < 6; k++) push(0, 0, 0, 0, 0, 0, 1, 0, 0);
                    return;
                end
                4'h4: mpc = {4'h0, w[11:0]};
                4'h5: if (w[11]) mpc = mpc + {{8{w[7]}}, w[7:0]};
                4'h2: begin
                    wtab[nacc] = dw; nacc++;
                    for (int k = 0; k <= dw; k++) push(1, 0, a, 0, 0, 0, 0, 0, 0);
                    push(0, 0, 0, 0, 1, 1, 0, 1, mem[a]);
                end
                4'h3: begin
                    wtab[nacc] = dw; nacc++;
                    for (int k = 0; k <= dw; k++)
                        push(1, 1, a, {w[7:0], ~w[7:0]}, 0, 0, 0, 0, 0);
                end
                4'h1, 4'h6: push(0, 0, 0, 0, 1, 0, 0, 0, 0);
                default: ;
            endcase
`ifdef SEQ_SINGLE_STEP_EN
            push(0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
        end
        wtab[nacc] = 1000;
    endtask

    task automatic compare_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_rd = 0;
            end else if (exp_rd < exp_n) begin
                e = exp_a[exp_rd];
                chk("req", 16'(mem_req), 16'(e.req));
                chk("pc", pc, e.pc);
                chk("halted", 16'(halted), 16'(e.hlt));
                chk("rf_we", 16'(rf_we), 16'(e.rfwe));
                if (e.req) begin
                    chk("mem_we", 16'(mem_we), 16'(e.we));
                    chk("mem_addr", mem_addr, e.addr);
                end
                if (e.req && e.we) chk("mem_wdata", mem_wdata, e.wdata);
                if (e.rfwe) chk("rf_wdata_sel", 16'(rf_wdata_sel), 16'(e.sel));
                if (e.ldchk) chk("load_data", load_data, e.ld);
                exp_rd++;
            end
        end
    endtask

    task automatic begin_test();
        rst_n = 1'b0;
        ready_force = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 256; i++) wtab[i] = 0;
        exp_n = 0; nacc = 0; mpc = 16'h0000;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic go();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain(input int budget, input bit toggle);
        int b = budget;
        while (exp_rd < exp_n && b > 0) begin
            @(negedge clk);
            b--;
            if (toggle) ready_force = ~ready_force;
        end
        @(negedge clk);
        #1;
        if (exp_rd < exp_n) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d of %0d records left", exp_n - exp_rd, exp_n);
        end
        ready_force = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0; n_bad = 0; exp_n = 0; exp_rd = 0;
        fork compare_loop(); join_none

        // Reset values, then ADD with zero-wait memory.
        begin_test();
        #1;
        chk("rst state", 16'(state), 16'(BOOT_ST));
        chk("rst pc", pc, 16'h0000);
        chk("rst instr", instr, 16'h0000);
        chk("rst load_data", load_data, 16'h0000);
        chk("rst mem_req", 16'(mem_req), 16'h0000);
        chk("rst mem_addr", mem_addr, 16'h0000);
        chk("rst rf_we", 16'(rf_we), 16'h0000);
        chk("rst halted", 16'(halted), 16'h0000);
        mem[0] = 16'h1123;
        model_run(1, 0, 0);
        go();
        drain(60, 0);
        chk("t1 pc", pc, 16'h0001);
        chk("t1 req cycle", 16'(req_cyc), 16'd1);
        chk("t1 rf_we count", 16'(rfwe_cnt), 16'd1);
        chk("t1 rf_we cycle", 16'(rfwe_cyc), 16'd4);

        // LD with three data wait states.
        begin_test();
        mem[0] = 16'h2040;
        mem[16'h0240] = 16'hBEEF;
        model_run(1, 0, 3);
        go();
        drain(60, 0);
        chk("t2 load_data", load_data, 16'hBEEF);
        chk("t2 sel", 16'(rf_wdata_sel), 16'h0001);
        chk("t2 rf_we cycle", 16'(rfwe_cyc), 16'd8);

        // ST, MOV, undefined, NOP, LD with fetch and data waits.
        begin_test();
        mem[0] = 16'h3155;
        mem[1] = 16'h6000;
        mem[2] = 16'h7000;
        mem[3] = 16'h0000;
        mem[4] = 16'h2010;
        mem[16'h0210] = 16'h1234;
        model_run(5, 1, 2);
        go();
        drain(120, 0);
        chk("t2b pc", pc, 16'h0005);
        chk("t2b rf_we count", 16'(rfwe_cnt), 16'd2);
        chk("t2b load_data", load_data, 16'h1234);

        // BEQZ at 0x0010, imm8=0xFE, taken.
        begin_test();
        mem[0] = 16'h4010;
        mem[16'h0010] = 16'h58FE;
        model_run(2, 0, 0);
        go();
        drain(60, 0);
        chk("t3 taken pc", pc, 16'h000F);

        // Same branch, not taken.
        begin_test();
        mem[0] = 16'h4010;
        mem[16'h0010] = 16'h50FE;
        model_run(2, 0, 0);
        go();
        drain(60, 0);
        chk("t3 not-taken pc", pc, 16'h0011);

        // Branch back to 0xFFFF, then JMP 0xABC across the wrap.
        begin_test();
        mem[0] = 16'h58FE;
        mem[16'hFFFF] = 16'h4ABC;
        model_run(2, 0, 0);
        go();
        drain(60, 0);
        chk("t4 pc", pc, 16'h0ABC);
        chk("t4 mem_addr", mem_addr, 16'h0ABC);

        // HLT with mem_ready toggling, then reset pulse.
        begin_test();
        mem[0] = 16'h1123;
        mem[1] = 16'hF000;
        model_run(2, 0, 0);
        go();
        drain(60, 1);
        chk("t5 halted", 16'(halted), 16'h0001);
        chk("t5 state", 16'(state), 16'd5);
        chk("t5 mem_req", 16'(mem_req), 16'h0000);
        chk("t5 pc", pc, 16'h0002);
        rst_n = 1'b0;
        #1;
        chk("t5 rst pc", pc, 16'h0000);
        chk("t5 rst halted", 16'(halted), 16'h0000);
        chk("t5 rst state", 16'(state), 16'(BOOT_ST));

        // Reset during a fetch wait, then two instructions.
        begin_test();
        mem[0] = 16'h1123;
        mem[1] = 16'h1456;
        wtab[0] = 5;
        go();
        repeat (3) @(negedge clk);
        #1;
        chk("t6 waiting req", 16'(mem_req), 16'h0001);
        rst_n = 1'b0;
        #1;
        chk("t6 async req drop", 16'(mem_req), 16'h0000);
        chk("t6 rst state", 16'(state), 16'(BOOT_ST));
        for (int i = 0; i < 256; i++) wtab[i] = 0;
        exp_n = 0; nacc = 0; mpc = 16'h0000;
`ifdef SEQ_SINGLE_STEP_EN
        step_req = 1'b0;
        @(negedge clk);
        go();
        repeat (4) @(negedge clk);
        #1;
        chk("t6 paused state", 16'(state), 16'd6);
        chk("t6 paused req", 16'(mem_req), 16'h0000);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            #1;
            model_run(1, 0, 0);
            step_req = 1'b1;
            @(posedge clk);
            #1 step_req = 1'b0;
            drain(60, 0);
            repeat (3) @(negedge clk);
        end
        #1;
        chk("t6 final state", 16'(state), 16'd6);
        step_req = 1'b1;
`else
        model_run(2, 0, 0);
        @(negedge clk);
        go();
        drain(60, 0);
`endif
        chk("t6 rf_we count", 16'(rfwe_cnt), 16'd2);
        chk("t6 pc", pc, 16'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle fetch/decode/execute sequencer for the 16-bit Von Neumann RISC core. It owns the PC and the instruction register, and it arbitrates the single shared memory port between instruction fetch and LD/ST data access. It consumes the combinational control-unit decode of the IR opcode, IR[15:12]. It drives the memory request handshake and the register-file write strobe.

Parameters:
ADDR_W, 16, width of PC and memory address
DATA_W, 16, width of instruction and data words
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_req  out  1  memory request; held high until accepted
mem_we  out  1  write strobe, valid while mem_req=1
mem_addr  out  ADDR_W  memory address, valid while mem_req=1
mem_wdata  out  DATA_W  store data, valid while mem_req=1 and mem_we=1
mem_rdata  in  DATA_W  read data, valid in the cycle mem_ready=1
mem_ready  in  1  accepts the current request / read data valid
instr  out  DATA_W  instruction register; IR[15:12] feeds the control-unit opcode
ctl_reg_write  in  1  control unit: register write
ctl_mem_write  in  1  control unit: memory write
ctl_mem_to_reg  in  1  control unit: write-back source is memory
ctl_mem_addr_sel  in  1  control unit: instruction accesses memory (LD/ST)
ctl_jump  in  1  control unit: jump
ctl_branch  in  1  control unit: branch-if-zero
ctl_halt  in  1  control unit: halt
alu_zero  in  1  ALU zero flag
alu_result  in  ADDR_W  ALU result, used as the data address
store_data  in  DATA_W  register data to store
rf_we  out  1  register-file write enable, one-cycle pulse
rf_wdata_sel  out  1  1 = load_data, 0 = ALU result
load_data  out  DATA_W  latched memory read data (MDR)
pc  out  ADDR_W  program counter
halted  out  1  core halted
state  out  3  current FSM state, for debug

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, pc=RESET_PC, instr=0, load_data=0.
  - mem_req, mem_we, rf_we, rf_wdata_sel and halted all 0.
  - mem_addr and mem_wdata are 0.
  - mem_req first rises in the first cycle after rst_n deasserts.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5.
- FETCH:
  - Drives mem_req=1, mem_we=0, mem_addr=pc.
  - On mem_ready=1: instr<=mem_rdata, pc<=pc+1 (wraps modulo 2^ADDR_W), go to DECODE.
  - Otherwise stay in FETCH with all outputs held stable.
- DECODE: one settling cycle for the control unit and ALU; no outputs change; go to EXEC.
- EXEC evaluates in this priority order:
  1. ctl_halt: go to HALTED, halted<=1.
  2. ctl_jump: pc <= zero-extended instr[11:0]; go to FETCH.
  3. ctl_branch: if alu_zero=1, pc <= pc + sign-extended instr[7:0] (pc already points past the branch), else pc unchanged; go to FETCH.
  4. ctl_mem_addr_sel: latch mem_addr<=alu_result, mem_wdata<=store_data, mem_we<=ctl_mem_write; go to MEM.
  5. ctl_reg_write: go to WB with rf_wdata_sel=0.
  6. Otherwise (NOP or undefined opcode): go to FETCH.
- MEM:
  - mem_req=1 with the latched address, data and we, held until mem_ready=1.
  - On ready with a load: load_data<=mem_rdata, rf_wdata_sel<=1, go to WB.
  - On ready with a store: go to FETCH.
- WB: rf_we=1 for exactly one cycle; go to FETCH.
- HALTED: terminal until reset; mem_req=0, rf_we=0.
- Memory handshake:
  - A transfer completes on the clock edge where mem_req=1 and mem_ready=1.
  - Zero-wait operation (mem_ready already high on the entry cycle) is legal and completes in one cycle.
  - mem_ready while mem_req=0 is ignored.
- Cycle counts with zero-wait memory, FETCH through return to FETCH:
  - ALU op / MOV: 4.
  - LD: 5.
  - ST: 4.
  - NOP / JMP / BEQZ: 3.
- Each memory wait cycle adds one cycle.
- rf_we never asserts outside WB, and at most once per instruction.
- Reset mid-transaction: mem_req and rf_we drop immediately (asynchronously); no partial state is retained.

Optional Feature:
Macro SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input port step_req (1 bit) and a PAUSE state, encoded 6.
  - Reset enters PAUSE instead of FETCH.
  - Every path that would return to FETCH goes to PAUSE instead.
  - PAUSE holds mem_req=0; a step_req=1 sample moves to FETCH, so exactly one instruction executes per pulse.
  - step_req held high runs continuously.
  - HALTED is still terminal.
- Not defined: no step_req port, no PAUSE state, free-running.

Test Plan:
1. Reset with RESET_PC=0, memory[0]=ADD R1,R2,R3, zero-wait memory -> mem_req rises 1 cycle after release; rf_we pulses exactly once, in cycle 4; pc=1.
2. LD with 3 wait states on the data access -> mem_addr=alu_result held stable for 4 cycles; load_data=mem_rdata; rf_wdata_sel=1 during the rf_we pulse; total 8 cycles.
3. BEQZ at pc=0x0010 with imm8=0xFE -> alu_zero=1 gives pc=0x000F; alu_zero=0 gives pc=0x0011.
4. JMP 0xABC at pc=0xFFFF -> fetch wraps pc to 0x0000; the jump then sets pc=0x0ABC.
5. HLT, then mem_ready toggling -> halted=1, mem_req stays 0; a rst_n pulse restores pc=RESET_PC.
6. Reset asserted during a FETCH wait, then (SEQ_SINGLE_STEP_EN) two step_req pulses -> mem_req drops immediately; stays in PAUSE until stepped; exactly 2 instructions execute.
